// File: rtl/spi_target_front_if.sv
// Data-side bundle of the SPI target front end.
// The slave modport is the front end; master is the stream-side user.
interface spi_target_front_if;
    logic [31:0] data_miso;
    logic [31:0] data_mosi;
    logic        rx_valid;
    logic        tx_req;
    logic        spi_wide;
    logic        spi_busy;
    logic        frame_err;

    modport master (
        output data_miso,
        output spi_wide,
        input  data_mosi,
        input  rx_valid,
        input  tx_req,
        input  spi_busy,
        input  frame_err
    );

    modport slave (
        input  data_miso,
        input  spi_wide,
        output data_mosi,
        output rx_valid,
        output tx_req,
        output spi_busy,
        output frame_err
    );
endinterface

// File: rtl/spi_target_front.sv
// Mode-0 MSB-first SPI target: oversampled pins, 8/32-bit words,
// MISO driven from the data interface.
module spi_target_front #(
    parameter int SYNC_STAGES = 2
) (
    input  logic spi_clk_in,
    input  logic rst_n,
    input  logic spi_sck_i,
    input  logic spi_cs_n_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic spi_miso_t,
    spi_target_front_if.slave bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic sck_s, cs_s, mosi_s;
    logic sck_d, cs_d;
    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;

    state_t state, state_nxt;

    logic        wide_r;
    logic [31:0] tx_sh;
    logic [30:0] rx_sh;
    logic [31:0] rx_nxt;
    logic [4:0]  bit_cnt;
    logic        word_done;
    logic        rise_seen;

    function automatic logic [31:0] pack(
        input logic [31:0] d,
        input logic        w
    );
        return w ? d : {d[7:0], 24'b0};
    endfunction

    always_ff @(posedge spi_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_d  <= sck_s;
            cs_d   <= cs_s;
        end
    end

    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign rx_nxt   = {rx_sh, mosi_s};

    always_ff @(posedge spi_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.spi_busy = (state == SHIFT);
        spi_miso_t   = (state != SHIFT);
    end

    assign spi_miso_o = tx_sh[31];

    always_ff @(posedge spi_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wide_r        <= 1'b0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            bit_cnt       <= '0;
            word_done     <= 1'b0;
            rise_seen     <= 1'b0;
            bus.data_mosi <= '0;
            bus.rx_valid  <= 1'b0;
            bus.tx_req    <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.tx_req    <= 1'b0;
            bus.frame_err <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    wide_r     <= bus.spi_wide;
                    tx_sh      <= pack(bus.data_miso, bus.spi_wide);
                    bit_cnt    <= bus.spi_wide ? 5'd31 : 5'd7;
                    bus.tx_req <= 1'b1;
                    word_done  <= 1'b0;
                    rise_seen  <= 1'b0;
                end
            end else if (cs_rise) begin
                // CS has priority over any SCK edge in the same cycle
                if (!word_done && rise_seen) bus.frame_err <= 1'b1;
                tx_sh     <= '0;
                word_done <= 1'b0;
                rise_seen <= 1'b0;
            end else if (sck_rise) begin
                rx_sh     <= rx_nxt[30:0];
                rise_seen <= 1'b1;
                if (bit_cnt == 5'd0) begin
                    bus.data_mosi <= wide_r ? rx_nxt : {24'b0, rx_nxt[7:0]};
                    bus.rx_valid  <= 1'b1;
                    word_done     <= 1'b1;
                end
            end else if (sck_fall) begin
                if (word_done) begin
                    tx_sh      <= pack(bus.data_miso, wide_r);
                    bit_cnt    <= wide_r ? 5'd31 : 5'd7;
                    bus.tx_req <= 1'b1;
                    word_done  <= 1'b0;
                    rise_seen  <= 1'b0;
                end else begin
                    tx_sh   <= {tx_sh[30:0], 1'b0};
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_target_front.sv
// Bench for spi_target_front: directed table, random frames against
// a word-level model, and abort / noise / reset sequences.
module tb_spi_target_front;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic miso_t;

    spi_target_front_if bus ();

    always #5 clk = ~clk;

    spi_target_front #(.SYNC_STAGES(2)) dut (
        .spi_clk_in (clk),
        .rst_n      (rst_n),
        .spi_sck_i  (sck),
        .spi_cs_n_i (cs_n),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .spi_miso_t (miso_t),
        .bus        (bus)
    );

    typedef struct {
        logic        wide;
        int          n;
        logic [31:0] mw [4];
        logic [31:0] tw [4];
        logic [31:0] erx [4];
        logic [31:0] etx [4];
    } vec_t;

    vec_t vt [5];

    int checks = 0;
    int failures = 0;
    int n_rx = 0;
    int n_tx = 0;
    int n_err = 0;
    logic [31:0] rx_q [$];
    logic [31:0] last_exp = 32'h0;

    always @(negedge clk) begin
        int np;
        if (rst_n) begin
            np = int'(bus.rx_valid) + int'(bus.tx_req) + int'(bus.frame_err);
            if (bus.rx_valid) begin
                n_rx++;
                rx_q.push_back(bus.data_mosi);
            end
            if (bus.tx_req) n_tx++;
            if (bus.frame_err) n_err++;
            if (np > 0) begin
                checks++;
                if (np > 1) begin
                    failures++;
                    $display("FAIL pulse_overlap: got %0d pulses want 1", np);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fit(input logic [31:0] x, input logic w);
        return w ? x : (x & 32'hFF);
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic m);
        mosi = b;
        clks(4);
        m = miso;
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, {31'b0, miso}, 32'h0);
        chk({tag, "_miso_t"}, {31'b0, miso_t}, 32'h1);
        chk({tag, "_data_mosi"}, bus.data_mosi, 32'h0);
        chk({tag, "_rx_valid"}, {31'b0, bus.rx_valid}, 32'h0);
        chk({tag, "_tx_req"}, {31'b0, bus.tx_req}, 32'h0);
        chk({tag, "_busy"}, {31'b0, bus.spi_busy}, 32'h0);
        chk({tag, "_frame_err"}, {31'b0, bus.frame_err}, 32'h0);
    endtask

    task automatic run_frame(input logic w, input int n,
                             input logic [31:0] mw [4],
                             input logic [31:0] tw [4],
                             input logic [31:0] erx [4],
                             input logic [31:0] etx [4]);
        int p_rx, p_tx, p_err, bits;
        logic m;
        logic [31:0] got;
        p_rx = n_rx;
        p_tx = n_tx;
        p_err = n_err;
        rx_q.delete();
        bits = w ? 32 : 8;
        bus.spi_wide = w;
        bus.data_miso = tw[0];
        cs_n = 1'b0;
        clks(8);
        chk("start_tx_req", n_tx - p_tx, 1);
        chk("start_busy", {31'b0, bus.spi_busy}, 32'h1);
        chk("start_miso_t", {31'b0, miso_t}, 32'h0);
        for (int k = 0; k < n; k++) begin
            got = 32'h0;
            for (int i = 0; i < bits; i++) begin
                bit_x(mw[k][bits-1-i], m);
                got = {got[30:0], m};
                if (i == 0 && k + 1 < n) bus.data_miso = tw[k+1];
                if (i == 1) bus.spi_wide = ~w;
            end
            chk("miso_word", got, etx[k]);
        end
        clks(6);
        cs_n = 1'b1;
        clks(8);
        chk("rx_count", n_rx - p_rx, n);
        chk("tx_count", n_tx - p_tx, n + 1);
        chk("err_count", n_err - p_err, 0);
        chk("rx_q_size", rx_q.size(), n);
        for (int k = 0; k < n && k < rx_q.size(); k++)
            chk("rx_word", rx_q[k], erx[k]);
        chk("end_data_mosi", bus.data_mosi, erx[n-1]);
        chk("end_busy", {31'b0, bus.spi_busy}, 32'h0);
        chk("end_miso_t", {31'b0, miso_t}, 32'h1);
        last_exp = erx[n-1];
    endtask

    task automatic set_vec(input int i, input logic w, input int n,
                           input logic [31:0] m0, input logic [31:0] m1,
                           input logic [31:0] t0, input logic [31:0] t1,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] x0, input logic [31:0] x1);
        vt[i].wide = w;
        vt[i].n = n;
        vt[i].mw = '{m0, m1, 32'h0, 32'h0};
        vt[i].tw = '{t0, t1, 32'h0, 32'h0};
        vt[i].erx = '{e0, e1, 32'h0, 32'h0};
        vt[i].etx = '{x0, x1, 32'h0, 32'h0};
    endtask

    initial begin
        logic [31:0] mw [4];
        logic [31:0] tw [4];
        logic [31:0] erx [4];
        logic [31:0] etx [4];
        logic w, m, bad;
        int n, p_rx, p_tx, p_err;

        set_vec(0, 1'b0, 1, 32'h3C, 32'h0, 32'hA5, 32'h0,
                32'h3C, 32'h0, 32'hA5, 32'h0);
        set_vec(1, 1'b1, 1, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h0,
                32'h12345678, 32'h0, 32'hDEADBEEF, 32'h0);
        set_vec(2, 1'b0, 2, 32'hC3, 32'h7E, 32'h11, 32'h5A,
                32'hC3, 32'h7E, 32'h11, 32'h5A);
        set_vec(3, 1'b0, 1, 32'hAB, 32'h0, 32'hCAFE0096, 32'h0,
                32'hAB, 32'h0, 32'h96, 32'h0);
        set_vec(4, 1'b1, 2, 32'h80000001, 32'hFFFFFFFF,
                32'h0F0F0F0F, 32'h00000000,
                32'h80000001, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00000000);

        bus.data_miso = 32'h0;
        bus.spi_wide = 1'b0;
        clks(2);
        chk_reset("por");
        rst_n = 1'b1;
        clks(4);

        for (int i = 0; i < 5; i++)
            run_frame(vt[i].wide, vt[i].n, vt[i].mw, vt[i].tw,
                      vt[i].erx, vt[i].etx);

        for (int r = 0; r < 6; r++) begin
            w = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                mw[k] = $urandom;
                tw[k] = $urandom;
                erx[k] = fit(mw[k], w);
                etx[k] = fit(tw[k], w);
            end
            run_frame(w, n, mw, tw, erx, etx);
        end

        // abort after three SCK rises
        p_rx = n_rx;
        p_err = n_err;
        bus.spi_wide = 1'b0;
        bus.data_miso = 32'h77;
        cs_n = 1'b0;
        clks(8);
        for (int i = 0; i < 3; i++) bit_x(1'b1, m);
        clks(4);
        cs_n = 1'b1;
        clks(4);
        chk("abort_busy", {31'b0, bus.spi_busy}, 32'h0);
        chk("abort_miso_t", {31'b0, miso_t}, 32'h1);
        clks(6);
        chk("abort_err", n_err - p_err, 1);
        chk("abort_rx", n_rx - p_rx, 0);
        chk("abort_data_mosi", bus.data_mosi, last_exp);

        // pin noise with CS high
        p_rx = n_rx;
        p_tx = n_tx;
        p_err = n_err;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sck = ~sck;
            mosi = 1'($urandom_range(0, 1));
            clks(2);
            if (miso_t !== 1'b1 || bus.spi_busy !== 1'b0) bad = 1'b1;
        end
        sck = 1'b0;
        clks(6);
        chk("noise_hiz", {31'b0, bad}, 32'h0);
        chk("noise_pulses", (n_rx - p_rx) + (n_tx - p_tx) + (n_err - p_err), 0);
        chk("noise_data_mosi", bus.data_mosi, last_exp);

        // reset in the middle of a word
        bus.spi_wide = 1'b0;
        bus.data_miso = 32'hFF;
        cs_n = 1'b0;
        clks(8);
        for (int i = 0; i < 4; i++) bit_x(1'b1, m);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        cs_n = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(4);
        run_frame(vt[0].wide, vt[0].n, vt[0].mw, vt[0].tw,
                  vt[0].erx, vt[0].etx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
